// File: rtl/pkt_pkg.sv
// Package shared by the packet bus arbiter files.
// Holds the default bus geometry, the ctl field layout {id, eop}, the FSM
// state type and a helper that slices one source beat out of the
// concatenated source bus (beat i lives at slice i).
package pkt_pkg;

  localparam int PKT_N_SRC     = 4;
  localparam int PKT_DATA_SIZE = 64;
  localparam int PKT_ID        = 2;
  localparam int PKT_CTL_SIZE  = PKT_ID + 1;
  localparam int PKT_CREDITS   = 16;
  localparam int PKT_BEAT_W    = PKT_DATA_SIZE + PKT_CTL_SIZE;

  // Bit positions inside the ctl field of a beat.
  localparam int EOP_BIT = 0;
  localparam int ID_LSB  = 1;

  typedef logic [$clog2(PKT_CREDITS+1)-1:0] credit_cnt_t;

  typedef struct packed {
    logic [PKT_ID-1:0] id;
    logic              eop;
  } pkt_ctl_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_t;

  // Returns beat idx of the concatenated source bus.
  function automatic logic [PKT_BEAT_W-1:0] pkt_get_beat(
    input logic [PKT_N_SRC*PKT_BEAT_W-1:0] bus,
    input int unsigned                     idx
  );
    return bus[idx*PKT_BEAT_W +: PKT_BEAT_W];
  endfunction

endpackage

// File: rtl/pkt_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req    in  N   request vector
//   rr_ptr in  PW  index with highest priority this cycle
//   winner out PW  first requester found searching upward from rr_ptr, with wrap
//   any    out 1   at least one request present
module pkt_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [PW-1:0] winner,
  output logic          any
);

  int idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/pkt_bus_arb.sv
// Packet-atomic round-robin arbiter for a credit-flow-controlled packet bus.
// A source keeps the grant from its first beat until the beat carrying eop.
// Every accepted beat spends one credit, every crd_return pulse refunds one.
// The outgoing beat has its id field overwritten with the granted index.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   src_valid    per-source beat present
//   src_bus      per-source beat {data, id, eop}, id bits ignored
//   src_ready    per-source beat accepted this cycle (combinational)
//   bus_valid    bus_out holds a new beat this cycle
//   bus_out      registered beat {data, grant id, eop}
//   crd_return   one receiver slot freed
//   credit_cnt   credits currently available
//   grant_id     source currently / last granted
//   busy         arbiter is inside a packet transfer
//   err          sticky credit overflow
//
// Handshake: a beat moves when src_valid[i] & src_ready[i]; src_ready is
// only ever raised for the granted source while credits remain, and a
// source may drop valid mid-packet without losing the grant.
module pkt_bus_arb
  import pkt_pkg::*;
#(
  parameter int N_SRC     = PKT_N_SRC,
  parameter int DATA_SIZE = PKT_DATA_SIZE,
  parameter int CTL_SIZE  = PKT_CTL_SIZE,
  parameter int ID        = PKT_ID,
  parameter int CREDITS   = PKT_CREDITS,
  localparam int BEAT_W   = DATA_SIZE + CTL_SIZE,
  localparam int CW       = $clog2(CREDITS + 1),
  localparam int GW       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*BEAT_W-1:0] src_bus,
  output logic [N_SRC-1:0]        src_ready,
  output logic                    bus_valid,
  output logic [BEAT_W-1:0]       bus_out,
  input  logic                    crd_return,
  output logic [CW-1:0]           credit_cnt,
  output logic [GW-1:0]           grant_id,
  output logic                    busy,
  output logic                    err
);

  arb_state_t        state_q, state_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]     grant_id_q, grant_id_d;
  logic              bus_valid_q, bus_valid_d;
  logic [BEAT_W-1:0] bus_out_q, bus_out_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic              err_q, err_d;

  logic [GW-1:0]     pick_winner;
  logic              pick_any;
  logic [BEAT_W-1:0] gbeat;
  pkt_ctl_t          ctl_out;
  logic              has_credit;
  logic              hs;

  pkt_rr_pick #(.N(N_SRC), .PW(GW)) u_pick (
    .req    (src_valid),
    .rr_ptr (rr_ptr_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  always_comb begin
    has_credit = (credit_q != '0);
    gbeat      = pkt_get_beat(src_bus, 32'(grant_id_q));
    ctl_out.id  = ID'(grant_id_q);
    ctl_out.eop = gbeat[EOP_BIT];

    src_ready = '0;
    if (state_q == ST_XFER && has_credit) begin
      src_ready[grant_id_q] = src_valid[grant_id_q];
    end
    hs = (state_q == ST_XFER) && src_valid[grant_id_q] && has_credit;

    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    bus_valid_d = 1'b0;
    bus_out_d   = bus_out_q;
    credit_d    = credit_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        // Credits are not needed to win; the grant simply waits in XFER.
        if (pick_any) begin
          grant_id_d = pick_winner;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (hs) begin
          bus_valid_d = 1'b1;
          bus_out_d   = {gbeat[BEAT_W-1:CTL_SIZE], ctl_out};
          if (ctl_out.eop) begin
            rr_ptr_d = (grant_id_q == GW'(N_SRC - 1)) ? '0 : grant_id_q + 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A refund and a spend in the same cycle cancel out.
    case ({crd_return, hs})
      2'b01: credit_d = credit_q - 1'b1;
      2'b10: begin
        if (credit_q == CW'(CREDITS)) err_d = 1'b1;
        else                          credit_d = credit_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      bus_valid_q <= 1'b0;
      bus_out_q   <= '0;
      credit_q    <= CW'(CREDITS);
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      bus_valid_q <= bus_valid_d;
      bus_out_q   <= bus_out_d;
      credit_q    <= credit_d;
      err_q       <= err_d;
    end
  end

  assign bus_valid  = bus_valid_q;
  assign bus_out    = bus_out_q;
  assign credit_cnt = credit_q;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q == ST_XFER);
  assign err        = err_q;

endmodule

// File: tb/tb_pkt_bus_arb.sv
// Directed bench for pkt_bus_arb: reset, single packet, round-robin order,
// credit drain/refund, simultaneous spend+refund, overflow error and
// reset in the middle of a packet.
module tb_pkt_bus_arb;
  import pkt_pkg::*;

  localparam int BW = 67;

  logic              clk;
  logic              rst;
  logic [3:0]        src_valid;
  logic [4*BW-1:0]   src_bus;
  logic [3:0]        src_ready;
  logic              bus_valid;
  logic [BW-1:0]     bus_out;
  logic              crd_return;
  credit_cnt_t       credit_cnt;
  logic [1:0]        grant_id;
  logic              busy;
  logic              err;

  int n_vec;
  int n_err;

  pkt_bus_arb dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_bus    (src_bus),
    .src_ready  (src_ready),
    .bus_valid  (bus_valid),
    .bus_out    (bus_out),
    .crd_return (crd_return),
    .credit_cnt (credit_cnt),
    .grant_id   (grant_id),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dat(input int t, input int a, input int b);
    return (64'(t) << 32) | (64'(a) << 16) | 64'(b);
  endfunction

  // Source beat with a deliberately wrong id so stamping is observable.
  function automatic logic [BW-1:0] src_beat(input logic [63:0] d, input logic e, input int s);
    logic [1:0] junk;
    junk = 2'(s + 1);
    return {d, junk, e};
  endfunction

  function automatic logic [BW-1:0] exp_beat(input logic [63:0] d, input int s, input logic e);
    logic [1:0] id;
    id = 2'(s);
    return {d, id, e};
  endfunction

  task automatic set_src(input int s, input logic [BW-1:0] b);
    src_bus[s*BW +: BW] = b;
  endtask

  initial begin
    int order[5] = '{1, 2, 3, 0, 1};
    int g;
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    src_valid = '0;
    src_bus = '0;
    crd_return = 1'b0;

    // ---- 1: reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_credit_in_reset", credit_cnt, 16);
    rst = 1'b1;
    step();
    chk("t1_credit", credit_cnt, 16);
    chk("t1_bus_valid", bus_valid, 0);
    chk("t1_bus_out", bus_out, 0);
    chk("t1_src_ready", src_ready, 0);
    chk("t1_err", err, 0);
    chk("t1_busy", busy, 0);
    chk("t1_grant", grant_id, 0);

    // ---- 2: src0 alone, 3-beat packet
    set_src(0, src_beat(dat(2, 0, 0), 1'b0, 0));
    src_valid = 4'b0001;
    #1 chk("t2_idle_ready", src_ready, 0);
    step();
    chk("t2_busy", busy, 1);
    chk("t2_grant", grant_id, 0);
    chk("t2_ready_b0", src_ready, 4'b0001);
    step();
    chk("t2_valid_b0", bus_valid, 1);
    chk("t2_out_b0", bus_out, exp_beat(dat(2, 0, 0), 0, 1'b0));
    chk("t2_credit_b0", credit_cnt, 15);
    set_src(0, src_beat(dat(2, 0, 1), 1'b0, 0));
    #1 chk("t2_ready_b1", src_ready, 4'b0001);
    step();
    chk("t2_out_b1", bus_out, exp_beat(dat(2, 0, 1), 0, 1'b0));
    chk("t2_credit_b1", credit_cnt, 14);
    set_src(0, src_beat(dat(2, 0, 2), 1'b1, 0));
    #1 chk("t2_ready_b2", src_ready, 4'b0001);
    step();
    chk("t2_out_b2", bus_out, exp_beat(dat(2, 0, 2), 0, 1'b1));
    chk("t2_credit_b2", credit_cnt, 13);
    chk("t2_busy_end", busy, 0);
    src_valid = '0;
    #1 chk("t2_ready_idle", src_ready, 0);
    step();
    chk("t2_valid_off", bus_valid, 0);
    chk("t2_out_hold", bus_out, exp_beat(dat(2, 0, 2), 0, 1'b1));

    // refill to 16
    crd_return = 1'b1;
    repeat (3) step();
    crd_return = 1'b0;
    chk("refill_credit", credit_cnt, 16);
    chk("refill_err", err, 0);

    // ---- 3: all sources valid, 2-beat packets; rr_ptr is 1 after test 2
    for (int s = 0; s < 4; s++) set_src(s, src_beat(dat(3, s, 0), 1'b0, s));
    src_valid = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      g = order[p];
      set_src(g, src_beat(dat(3, p, 0), 1'b0, g));
      crd_return = 1'b0;
      #1 chk("t3_idle_ready", src_ready, 0);
      chk("t3_idle_busy", busy, 0);
      step();
      chk("t3_grant", grant_id, g);
      crd_return = 1'b1;
      #1 chk("t3_ready_b0", src_ready, 128'(1) << g);
      step();
      chk("t3_out_b0", bus_out, exp_beat(dat(3, p, 0), g, 1'b0));
      chk("t3_credit_b0", credit_cnt, 16);
      set_src(g, src_beat(dat(3, p, 1), 1'b1, g));
      #1 chk("t3_ready_b1", src_ready, 128'(1) << g);
      step();
      chk("t3_out_b1", bus_out, exp_beat(dat(3, p, 1), g, 1'b1));
      chk("t3_busy_end", busy, 0);
      chk("t3_credit_b1", credit_cnt, 16);
    end
    crd_return = 1'b0;
    src_valid = '0;
    step();
    chk("t3_err", err, 0);

    // ---- 4: credit drain, src1 20-beat packet; rr_ptr is 2
    set_src(1, src_beat(dat(4, 0, 0), 1'b0, 1));
    src_valid = 4'b0010;
    #1 chk("t4_idle_ready", src_ready, 0);
    step();
    chk("t4_grant", grant_id, 1);
    for (int b = 0; b < 16; b++) begin
      set_src(1, src_beat(dat(4, 0, b), 1'b0, 1));
      #1 chk("t4_ready", src_ready, 4'b0010);
      step();
      chk("t4_out", bus_out, exp_beat(dat(4, 0, b), 1, 1'b0));
    end
    chk("t4_credit_zero", credit_cnt, 0);
    set_src(1, src_beat(dat(4, 0, 16), 1'b0, 1));
    #1 chk("t4_ready_stall", src_ready, 0);
    step();
    chk("t4_valid_stall", bus_valid, 0);
    chk("t4_credit_stall", credit_cnt, 0);
    chk("t4_busy_stall", busy, 1);
    crd_return = 1'b1;
    step();
    crd_return = 1'b0;
    chk("t4_credit_one", credit_cnt, 1);
    #1 chk("t4_ready_one", src_ready, 4'b0010);
    step();
    chk("t4_valid_one", bus_valid, 1);
    chk("t4_out_one", bus_out, exp_beat(dat(4, 0, 16), 1, 1'b0));
    chk("t4_credit_back0", credit_cnt, 0);
    chk("t4_ready_back0", src_ready, 0);
    step();
    chk("t4_valid_after", bus_valid, 0);

    // ---- 5: source drops valid mid-packet, gather 5 credits
    src_valid = '0;
    set_src(1, src_beat(dat(4, 0, 17), 1'b0, 1));
    crd_return = 1'b1;
    repeat (5) step();
    crd_return = 1'b0;
    chk("t5_credit5", credit_cnt, 5);
    chk("t5_busy_hold", busy, 1);
    chk("t5_grant_hold", grant_id, 1);
    chk("t5_ready_novalid", src_ready, 0);
    src_valid = 4'b0010;
    crd_return = 1'b1;
    #1 chk("t5_ready", src_ready, 4'b0010);
    step();
    chk("t5_credit_same", credit_cnt, 5);
    chk("t5_out17", bus_out, exp_beat(dat(4, 0, 17), 1, 1'b0));
    crd_return = 1'b0;
    set_src(1, src_beat(dat(4, 0, 18), 1'b0, 1));
    step();
    chk("t5_credit4", credit_cnt, 4);
    set_src(1, src_beat(dat(4, 0, 19), 1'b1, 1));
    step();
    chk("t5_credit3", credit_cnt, 3);
    chk("t5_out19", bus_out, exp_beat(dat(4, 0, 19), 1, 1'b1));
    chk("t5_busy_end", busy, 0);
    src_valid = '0;
    crd_return = 1'b1;
    repeat (13) step();
    chk("t5_credit_full", credit_cnt, 16);
    chk("t5_err_before", err, 0);
    step();
    crd_return = 1'b0;
    chk("t5_credit_sat", credit_cnt, 16);
    chk("t5_err_set", err, 1);
    repeat (3) step();
    chk("t5_err_sticky", err, 1);

    // ---- 6: reset in the middle of a 4-beat packet from src2; rr_ptr is 2
    set_src(2, src_beat(dat(6, 0, 0), 1'b0, 2));
    src_valid = 4'b0100;
    step();
    chk("t6_grant", grant_id, 2);
    step();
    set_src(2, src_beat(dat(6, 0, 1), 1'b0, 2));
    step();
    chk("t6_credit14", credit_cnt, 14);
    set_src(2, src_beat(dat(6, 0, 2), 1'b0, 2));
    #1 chk("t6_ready_b2", src_ready, 4'b0100);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", bus_valid, 0);
    chk("t6_rst_out", bus_out, 0);
    chk("t6_rst_ready", src_ready, 0);
    chk("t6_rst_credit", credit_cnt, 16);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_grant", grant_id, 0);
    step();
    rst = 1'b1;
    for (int s = 0; s < 4; s++) set_src(s, src_beat(dat(6, 1, s), 1'b1, s));
    src_valid = 4'b1111;
    step();
    chk("t6_restart_grant", grant_id, 0);
    chk("t6_restart_ready", src_ready, 4'b0001);
    step();
    chk("t6_restart_out", bus_out, exp_beat(dat(6, 1, 0), 0, 1'b1));
    src_valid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
